// File: rtl/kbd_decoder.sv
// rtl/kbd_decoder.sv - PS/2 set-2 scan-code decoder with make/break/E0 tracking.
// Optional set-2 to ASCII lookup is compiled in when KBD_ASCII_EN is defined.
module kbd_decoder (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       key_valid,
  output logic       key_down,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic [7:0] ascii,
  output logic [7:0] press_count,
  output logic       err
);

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DECODE} state_t;

  state_t     state_q;
  logic [7:0] byte_q;
  logic       brk_q;
  logic       ext_q;
  logic       nextdata_n_q;
  logic       valid_q;
  logic       down_q;
  logic [7:0] code_q;
  logic       sext_q;
  logic [7:0] count_q;
  logic       err_q;

  logic is_prefix;
  logic is_repeat;
  logic decode_event;

  // A held key re-sent by typematic repeat is swallowed silently.
  assign is_prefix    = (byte_q == BYTE_BREAK) || (byte_q == BYTE_EXT);
  assign is_repeat    = down_q && (byte_q == code_q) && (ext_q == sext_q);
  assign decode_event = (state_q == S_DECODE) && !is_prefix && (brk_q || !is_repeat);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      valid_q      <= 1'b0;
      down_q       <= 1'b0;
      code_q       <= 8'h00;
      sext_q       <= 1'b0;
      count_q      <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (kb_overflow) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (kb_ready) begin
            byte_q       <= kb_data;
            nextdata_n_q <= 1'b0;
            state_q      <= S_ACK;
          end
        end
        S_ACK: begin
          nextdata_n_q <= 1'b1;
          state_q      <= S_DECODE;
        end
        S_DECODE: begin
          state_q <= S_IDLE;
          if (byte_q == BYTE_BREAK) begin
            brk_q <= 1'b1;
          end else if (byte_q == BYTE_EXT) begin
            ext_q <= 1'b1;
          end else begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            if (brk_q) begin
              code_q  <= byte_q;
              sext_q  <= ext_q;
              down_q  <= 1'b0;
              valid_q <= 1'b1;
            end else if (!is_repeat) begin
              code_q  <= byte_q;
              sext_q  <= ext_q;
              down_q  <= 1'b1;
              count_q <= count_q + 8'd1;
              valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign kb_nextdata_n = nextdata_n_q;
  assign key_valid     = valid_q;
  assign key_down      = down_q;
  assign scan_code     = code_q;
  assign scan_ext      = sext_q;
  assign press_count   = count_q;
  assign err           = err_q;

`ifdef KBD_ASCII_EN
  function automatic logic [7:0] set2_ascii(input logic [7:0] code);
    case (code)
      8'h1C: set2_ascii = 8'h61;  8'h32: set2_ascii = 8'h62;  8'h21: set2_ascii = 8'h63;
      8'h23: set2_ascii = 8'h64;  8'h24: set2_ascii = 8'h65;  8'h2B: set2_ascii = 8'h66;
      8'h34: set2_ascii = 8'h67;  8'h33: set2_ascii = 8'h68;  8'h43: set2_ascii = 8'h69;
      8'h3B: set2_ascii = 8'h6A;  8'h42: set2_ascii = 8'h6B;  8'h4B: set2_ascii = 8'h6C;
      8'h3A: set2_ascii = 8'h6D;  8'h31: set2_ascii = 8'h6E;  8'h44: set2_ascii = 8'h6F;
      8'h4D: set2_ascii = 8'h70;  8'h15: set2_ascii = 8'h71;  8'h2D: set2_ascii = 8'h72;
      8'h1B: set2_ascii = 8'h73;  8'h2C: set2_ascii = 8'h74;  8'h3C: set2_ascii = 8'h75;
      8'h2A: set2_ascii = 8'h76;  8'h1D: set2_ascii = 8'h77;  8'h22: set2_ascii = 8'h78;
      8'h35: set2_ascii = 8'h79;  8'h1A: set2_ascii = 8'h7A;
      8'h45: set2_ascii = 8'h30;  8'h16: set2_ascii = 8'h31;  8'h1E: set2_ascii = 8'h32;
      8'h26: set2_ascii = 8'h33;  8'h25: set2_ascii = 8'h34;  8'h2E: set2_ascii = 8'h35;
      8'h36: set2_ascii = 8'h36;  8'h3D: set2_ascii = 8'h37;  8'h3E: set2_ascii = 8'h38;
      8'h46: set2_ascii = 8'h39;
      8'h29: set2_ascii = 8'h20;  8'h5A: set2_ascii = 8'h0D;  8'h66: set2_ascii = 8'h08;
      default: set2_ascii = 8'h00;
    endcase
  endfunction

  logic [7:0] ascii_q;

  // Tracks scan_code on every reported event; extended keys have no ASCII.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ascii_q <= 8'h00;
    end else if (decode_event) begin
      ascii_q <= ext_q ? 8'h00 : set2_ascii(byte_q);
    end
  end

  assign ascii = ascii_q;
`else
  logic unused_event;
  assign unused_event = decode_event;
  assign ascii        = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_decoder.sv
// tb/tb_kbd_decoder.sv - scoreboard bench for kbd_decoder with a FIFO model and random byte streams.
module tb_kbd_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n;
  logic       key_valid;
  logic       key_down;
  logic [7:0] scan_code;
  logic       scan_ext;
  logic [7:0] ascii;
  logic [7:0] press_count;
  logic       err;

  kbd_decoder dut (
    .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .key_valid(key_valid),
    .key_down(key_down), .scan_code(scan_code), .scan_ext(scan_ext), .ascii(ascii),
    .press_count(press_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       down;
    logic [7:0] code;
    logic       ext;
    logic [7:0] asc;
    logic [7:0] cnt;
  } event_t;

  logic [7:0] fifo[$];
  event_t     exp_q[$];
  int         total = 0;
  int         passed = 0;
  int         pops = 0;

  // Reference decoder state, expressed as "what the keyboard last told us".
  bit         m_brk, m_ext, m_down, m_cext;
  logic [7:0] m_code;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit ext);
`ifdef KBD_ASCII_EN
    logic [7:0] tbl[36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                            8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    string chars = "abcdefghijklmnopqrstuvwxyz0123456789";
    if (ext) return 8'h00;
    for (int i = 0; i < 36; i++) if (tbl[i] == code) return chars[i];
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    if (code == 8'h66) return 8'h08;
    return 8'h00;
`else
    return 8'h00 & {code[0] & ext, 7'h00};
`endif
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_down = 0; m_cext = 0; m_code = 8'h00; m_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    event_t e;
    fifo.push_back(b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin
      m_down = 0; m_code = b; m_cext = m_ext; m_brk = 0; m_ext = 0;
      e = '{0, b, m_cext, ref_ascii(b, m_cext), 8'(m_cnt)};
      exp_q.push_back(e);
    end else if (m_down && b == m_code && m_ext == m_cext) begin
      m_ext = 0;
    end else begin
      m_down = 1; m_code = b; m_cext = m_ext; m_ext = 0;
      m_cnt = (m_cnt + 1) % 256;
      e = '{1, b, m_cext, ref_ascii(b, m_cext), 8'(m_cnt)};
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("drain_timeout", n < 5000, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_nextdata_n"}, kb_nextdata_n, 1);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_key_down"}, key_down, 0);
    chk({tag, "_scan_code"}, scan_code, 0);
    chk({tag, "_scan_ext"}, scan_ext, 0);
    chk({tag, "_ascii"}, ascii, 0);
    chk({tag, "_press_count"}, press_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // FIFO model: pops on the edge where the strobe is low, presents the new head just after.
  always @(posedge clk) begin
    logic [7:0] dropped;
    if (!kb_nextdata_n && fifo.size() > 0) dropped = fifo.pop_front();
    #1;
    kb_ready = (fifo.size() != 0);
    kb_data  = kb_ready ? fifo[0] : 8'h00;
  end

  always @(negedge clk) begin
    event_t e;
    if (!kb_nextdata_n) pops++;
    if (resetn && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL spurious_key_valid: got pulse scan_code=%0h, expected no event", scan_code);
      end else begin
        e = exp_q.pop_front();
        chk("ev_key_down", key_down, e.down);
        chk("ev_scan_code", scan_code, e.code);
        chk("ev_scan_ext", scan_ext, e.ext);
        chk("ev_ascii", ascii, e.asc);
        chk("ev_press_count", press_count, e.cnt);
      end
    end
  end

  initial begin
    int pops0;
    int n;
    logic [7:0] c;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    resetn = 1;

    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    chk("make_break_count", press_count, 1);

    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    chk("typematic_count", press_count, 2);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    chk("ext_break_scan_ext", scan_ext, 1);

    for (int i = 0; i < 150; i++) begin
      bit ext;
      ext = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: begin
          c = 8'($urandom_range(1, 8'hDF));
          if (ext) send(8'hE0);
          send(c);
        end
        1: begin
          if (m_cext) send(8'hE0);
          send(8'hF0); send(m_code == 8'h00 ? 8'h1C : m_code);
        end
        2: begin
          if (ext) send(8'hE0);
          send(8'hF0); send(8'($urandom_range(1, 8'hDF)));
        end
        default: begin
          if (m_cext) send(8'hE0);
          send(m_code == 8'h00 ? 8'h29 : m_code);
        end
      endcase
    end
    drain();

    do_reset();
    chk("pre_wrap_count", press_count, 0);
    pops0 = pops;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      if (c == 8'hE0 || c == 8'hF0) c = 8'h5A;
      send(c); send(8'hF0); send(c);
    end
    drain();
    chk("wrap_count", press_count, 0);
    chk("pop_count_768", pops - pops0, 768);

    chk("err_before_overflow", err, 0);
    kb_overflow = 1;
    @(negedge clk);
    kb_overflow = 0;
    chk("err_set", err, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);

    pops0 = pops;
    fifo.push_back(8'h1C);
    n = 0;
    while (kb_nextdata_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", kb_nextdata_n, 0);
    resetn = 0;
    model_reset();
    @(negedge clk);
    chk_zero_outputs("ack_reset");
    resetn = 1;
    repeat (10) @(negedge clk);
    chk("ack_reset_single_pop", pops - pops0, 1);
    chk("ack_reset_fifo_empty", fifo.size(), 0);
    chk("ack_reset_no_event", press_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
